// File: rtl/peripheral_ahb3_pkg.sv
// ---------------------------------------------------------------------------
// peripheral_ahb3_pkg
// Shared AHB3-Lite encodings and the AHB3-to-APB4 bridge state type.
//   HTRANS_*  transfer type encodings
//   HSIZE_*   transfer size encodings
//   HRESP_*   response encodings
//   HPROT_*   bit positions inside HPROT
//   bridge_state_t  bridge FSM states
// ---------------------------------------------------------------------------
package peripheral_ahb3_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HWORD = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;
   localparam logic [2:0] HSIZE_B128  = 3'b100;
   localparam logic [2:0] HSIZE_B256  = 3'b101;
   localparam logic [2:0] HSIZE_B512  = 3'b110;
   localparam logic [2:0] HSIZE_B1024 = 3'b111;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam int HPROT_DATA       = 0;
   localparam int HPROT_PRIVILEGED = 1;
   localparam int HPROT_BUFFERABLE = 2;
   localparam int HPROT_CACHEABLE  = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DATA   = 3'd1,
      ST_PEND   = 3'd2,
      ST_SETUP  = 3'd3,
      ST_ACCESS = 3'd4,
      ST_ERR1   = 3'd5,
      ST_ERR2   = 3'd6
   } bridge_state_t;

endpackage

// File: rtl/peripheral_apb4_lane_ctrl.sv
// ---------------------------------------------------------------------------
// peripheral_apb4_lane_ctrl
// Pure combinational beat geometry for the AHB3-to-APB4 bridge.
// For a given AHB address/size and APB beat index it produces:
//   haddr  in   latched AHB address
//   hsize  in   latched AHB size
//   beat   in   APB beat index within the AHB access
//   paddr  out  APB address of that beat (wraps modulo 2^PADDR_SIZE)
//   lane   out  first HDATA byte lane carried by that beat
//   pstrb  out  bytes of the APB word covered by [haddr, haddr+2^hsize)
// ---------------------------------------------------------------------------
module peripheral_apb4_lane_ctrl
   import peripheral_ahb3_pkg::*;
#(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int PADDR_SIZE = 10,
   parameter int PDATA_SIZE = 8,
   parameter int BEAT_W     = 3,
   parameter int LANE_W     = 2
) (
   input  logic [HADDR_SIZE-1:0]   haddr,
   input  logic [2:0]              hsize,
   input  logic [BEAT_W-1:0]       beat,
   output logic [PADDR_SIZE-1:0]   paddr,
   output logic [LANE_W-1:0]       lane,
   output logic [PDATA_SIZE/8-1:0] pstrb
);

   localparam int PBYTES = PDATA_SIZE / 8;
   localparam int HBYTES = HDATA_SIZE / 8;
   localparam logic [PADDR_SIZE-1:0] PMASK = ~PADDR_SIZE'(PBYTES - 1);

   int lo;
   int off;
   int beat_ofs;
   int nbytes;
   int lane_i;
   int rel;

   // Upper address bits only matter to the AHB decoder, not to beat geometry.
   logic unused_haddr;
   assign unused_haddr = ^haddr;

   always_comb begin
      lo       = int'(haddr[LANE_W-1:0]);
      off      = lo & (PBYTES - 1);
      beat_ofs = int'(beat) * PBYTES;
      nbytes   = 1 << hsize;
      // Lane wraps within the HDATA word; masks collapse to 0 when HBYTES=1.
      lane_i   = ((lo & (HBYTES - 1) & ~(PBYTES - 1)) + beat_ofs) & (HBYTES - 1);
      lane     = LANE_W'(lane_i);
      paddr    = (haddr[PADDR_SIZE-1:0] & PMASK) + PADDR_SIZE'(beat_ofs);
      rel      = 0;
      pstrb    = '0;
      // Byte i of this beat sits at (beat_ofs + i - off) bytes past HADDR.
      for (int i = 0; i < PBYTES; i++) begin
         rel      = beat_ofs + i - off;
         pstrb[i] = (rel >= 0) && (rel < nbytes);
      end
   end

endmodule

// File: rtl/peripheral_ahb3_apb4_bridge.sv
// ---------------------------------------------------------------------------
// peripheral_ahb3_apb4_bridge
// Single-clock AHB3-Lite slave to APB4 master bridge. The APB side runs on
// HCLK qualified by PCLKEN; accesses wider than PDATA_SIZE are split into
// sequential APB beats. PSLVERR becomes a two-cycle AHB ERROR response.
//
// Ports
//   HCLK, HRESETn                    clock, async active-low reset
//   HSEL HWRITE HREADY HMASTLOCK     AHB control (HMASTLOCK ignored)
//   HADDR HWDATA HSIZE HBURST HPROT  AHB address/data/attributes (HBURST ignored)
//   HTRANS                           AHB transfer type
//   HRDATA HREADYOUT HRESP           AHB slave response
//   PCLKEN                           APB clock enable
//   PSEL PENABLE PWRITE PPROT PSTRB  APB master control
//   PADDR PWDATA                     APB address / write data
//   PRDATA PREADY PSLVERR            APB slave response
//
// Build option
//   PERIPHERAL_AHB3_APB4_TIMEOUT_EN  when defined, an ACCESS phase with
//   PREADY low for TIMEOUT enabled cycles is aborted with an AHB ERROR.
// ---------------------------------------------------------------------------
module peripheral_ahb3_apb4_bridge
   import peripheral_ahb3_pkg::*;
#(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int PADDR_SIZE = 10,
   parameter int PDATA_SIZE = 8,
   parameter int TIMEOUT    = 255
) (
   input  logic                    HCLK,
   input  logic                    HRESETn,
   input  logic                    HSEL,
   input  logic                    HWRITE,
   input  logic                    HREADY,
   input  logic                    HMASTLOCK,
   input  logic [HADDR_SIZE-1:0]   HADDR,
   input  logic [HDATA_SIZE-1:0]   HWDATA,
   output logic [HDATA_SIZE-1:0]   HRDATA,
   input  logic [2:0]              HSIZE,
   input  logic [2:0]              HBURST,
   input  logic [3:0]              HPROT,
   input  logic [1:0]              HTRANS,
   output logic                    HREADYOUT,
   output logic                    HRESP,
   input  logic                    PCLKEN,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [2:0]              PPROT,
   output logic [PDATA_SIZE/8-1:0] PSTRB,
   output logic [PADDR_SIZE-1:0]   PADDR,
   output logic [PDATA_SIZE-1:0]   PWDATA,
   input  logic [PDATA_SIZE-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   localparam int BEAT_W = $clog2(HDATA_SIZE / PDATA_SIZE) + 1;
   localparam int LANE_W = (HDATA_SIZE > 8) ? $clog2(HDATA_SIZE / 8) : 1;

   bridge_state_t state_q, state_d;

   logic [HADDR_SIZE-1:0]   haddr_q,  haddr_d;
   logic                    hwrite_q, hwrite_d;
   logic [2:0]              hsize_q,  hsize_d;
   logic [3:0]              hprot_q,  hprot_d;
   logic [HDATA_SIZE-1:0]   hwdata_q, hwdata_d;
   logic [BEAT_W-1:0]       beat_q,   beat_d;
   logic [LANE_W-1:0]       lane_q,   lane_d;

   logic [HDATA_SIZE-1:0]   hrdata_d;
   logic                    hreadyout_d;
   logic                    hresp_d;
   logic                    psel_d;
   logic                    penable_d;
   logic                    pwrite_d;
   logic [2:0]              pprot_d;
   logic [PDATA_SIZE/8-1:0] pstrb_d;
   logic [PADDR_SIZE-1:0]   paddr_d;
   logic [PDATA_SIZE-1:0]   pwdata_d;

   logic                    accept;
   logic                    size_err;
   logic                    last;
   logic                    load;
   logic [BEAT_W-1:0]       beat_sel;
   logic [HDATA_SIZE-1:0]   wdata_src;
   logic [PADDR_SIZE-1:0]   lc_paddr;
   logic [LANE_W-1:0]       lc_lane;
   logic [PDATA_SIZE/8-1:0] lc_pstrb;

`ifdef PERIPHERAL_AHB3_APB4_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT < 256) ? 8 : 16;
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   logic unused_in;
   assign unused_in = &{1'b0, HMASTLOCK, HBURST, HTRANS[0], hprot_q[3:2]};

   // Index of the final APB beat for a given AHB size.
   function automatic logic [BEAT_W-1:0] last_beat(input logic [2:0] hs);
      int n;
      n = (8 << hs) / PDATA_SIZE;
      if (n < 1) n = 1;
      return BEAT_W'(n - 1);
   endfunction

   assign accept   = HSEL & HREADY & HTRANS[1];
   assign size_err = (32'd8 << hsize_q) > 32'(HDATA_SIZE);
   assign last     = (beat_q == last_beat(hsize_q));
   // The geometry unit always looks at the beat about to be loaded.
   assign beat_sel = (state_q == ST_ACCESS) ? beat_q + 1'b1 : '0;
   // In DATA the write word is still on HWDATA, not yet in hwdata_q.
   assign wdata_src = (state_q == ST_DATA) ? HWDATA : hwdata_q;

   peripheral_apb4_lane_ctrl #(
      .HADDR_SIZE (HADDR_SIZE),
      .HDATA_SIZE (HDATA_SIZE),
      .PADDR_SIZE (PADDR_SIZE),
      .PDATA_SIZE (PDATA_SIZE),
      .BEAT_W     (BEAT_W),
      .LANE_W     (LANE_W)
   ) u_lane_ctrl (
      .haddr (haddr_q),
      .hsize (hsize_q),
      .beat  (beat_sel),
      .paddr (lc_paddr),
      .lane  (lc_lane),
      .pstrb (lc_pstrb)
   );

   always_comb begin
      state_d     = state_q;
      haddr_d     = haddr_q;
      hwrite_d    = hwrite_q;
      hsize_d     = hsize_q;
      hprot_d     = hprot_q;
      hwdata_d    = hwdata_q;
      beat_d      = beat_q;
      lane_d      = lane_q;
      hrdata_d    = HRDATA;
      hreadyout_d = HREADYOUT;
      hresp_d     = HRESP;
      psel_d      = PSEL;
      penable_d   = PENABLE;
      pwrite_d    = PWRITE;
      pprot_d     = PPROT;
      pstrb_d     = PSTRB;
      paddr_d     = PADDR;
      pwdata_d    = PWDATA;
      load        = 1'b0;
`ifdef PERIPHERAL_AHB3_APB4_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif

      case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
            if (accept) begin
               state_d     = ST_DATA;
               hreadyout_d = 1'b0;
               haddr_d     = HADDR;
               hwrite_d    = HWRITE;
               hsize_d     = HSIZE;
               hprot_d     = HPROT;
               hrdata_d    = '0;
            end
         end

         ST_DATA: begin
            hwdata_d = HWDATA;
            if (size_err) begin
               state_d = ST_ERR1;
               hresp_d = HRESP_ERROR;
            end else if (PCLKEN) begin
               state_d = ST_SETUP;
               beat_d  = '0;
               load    = 1'b1;
            end else begin
               state_d = ST_PEND;
            end
         end

         ST_PEND: begin
            if (PCLKEN) begin
               state_d = ST_SETUP;
               beat_d  = '0;
               load    = 1'b1;
            end
         end

         ST_SETUP: begin
            if (PCLKEN) begin
               state_d   = ST_ACCESS;
               penable_d = 1'b1;
`ifdef PERIPHERAL_AHB3_APB4_TIMEOUT_EN
               tmo_d     = '0;
`endif
            end
         end

         ST_ACCESS: begin
            if (PCLKEN && PREADY) begin
               hrdata_d[int'(lane_q)*8 +: PDATA_SIZE] = PRDATA;
               if (PSLVERR) begin
                  state_d   = ST_ERR1;
                  hresp_d   = HRESP_ERROR;
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
               end else if (last) begin
                  state_d     = ST_IDLE;
                  hreadyout_d = 1'b1;
                  hresp_d     = HRESP_OKAY;
                  psel_d      = 1'b0;
                  penable_d   = 1'b0;
               end else begin
                  state_d = ST_SETUP;
                  beat_d  = beat_sel;
                  load    = 1'b1;
               end
            end
`ifdef PERIPHERAL_AHB3_APB4_TIMEOUT_EN
            else if (PCLKEN) begin
               if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  state_d   = ST_ERR1;
                  hresp_d   = HRESP_ERROR;
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
                  hrdata_d[int'(lane_q)*8 +: PDATA_SIZE] = '0;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
`endif
         end

         ST_ERR1: begin
            state_d     = ST_ERR2;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_ERROR;
         end

         default: begin
            state_d     = ST_IDLE;
            hreadyout_d = 1'b1;
            hresp_d     = HRESP_OKAY;
         end
      endcase

      // Every path that sets load is already qualified by PCLKEN.
      if (load) begin
         psel_d    = 1'b1;
         penable_d = 1'b0;
         pwrite_d  = hwrite_q;
         pprot_d   = {~hprot_q[HPROT_DATA], 1'b0, hprot_q[HPROT_PRIVILEGED]};
         paddr_d   = lc_paddr;
         pstrb_d   = hwrite_q ? lc_pstrb : '0;
         pwdata_d  = wdata_src[int'(lc_lane)*8 +: PDATA_SIZE];
         lane_d    = lc_lane;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         haddr_q   <= '0;
         hwrite_q  <= 1'b0;
         hsize_q   <= '0;
         hprot_q   <= '0;
         hwdata_q  <= '0;
         beat_q    <= '0;
         lane_q    <= '0;
         HRDATA    <= '0;
         HREADYOUT <= 1'b1;
         HRESP     <= HRESP_OKAY;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PPROT     <= '0;
         PSTRB     <= '0;
         PADDR     <= '0;
         PWDATA    <= '0;
`ifdef PERIPHERAL_AHB3_APB4_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         haddr_q   <= haddr_d;
         hwrite_q  <= hwrite_d;
         hsize_q   <= hsize_d;
         hprot_q   <= hprot_d;
         hwdata_q  <= hwdata_d;
         beat_q    <= beat_d;
         lane_q    <= lane_d;
         HRDATA    <= hrdata_d;
         HREADYOUT <= hreadyout_d;
         HRESP     <= hresp_d;
         PSEL      <= psel_d;
         PENABLE   <= penable_d;
         PWRITE    <= pwrite_d;
         PPROT     <= pprot_d;
         PSTRB     <= pstrb_d;
         PADDR     <= paddr_d;
         PWDATA    <= pwdata_d;
`ifdef PERIPHERAL_AHB3_APB4_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

endmodule

// File: doc/peripheral_ahb3_apb4_bridge.md
Name: peripheral_ahb3_apb4_bridge

Overview:
- Single-clock AHB3-Lite slave to APB4 master bridge for GPIO/MPSoC peripheral buses.
- APB side runs on HCLK, qualified by the clock-enable PCLKEN, which supports integer APB:AHB clock ratios without a CDC.
- Splits any AHB access wider than PDATA_SIZE into sequential APB beats.
- Generates full APB4 PSTRB and returns PSLVERR as a two-cycle AHB ERROR.

Parameters:
- HADDR_SIZE, 32, AHB address width.
- HDATA_SIZE, 32, AHB data width; power of two, 8..1024.
- PADDR_SIZE, 10, APB address width.
- PDATA_SIZE, 8, APB data width; power of two, 8..HDATA_SIZE.
- TIMEOUT, 255, PREADY-low limit in enabled cycles (used only with the optional feature).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low; also resets the APB side.
- HSEL, HWRITE, HREADY, HMASTLOCK  in  1  AHB control (HMASTLOCK ignored).
- HADDR  in  HADDR_SIZE  address.
- HWDATA  in  HDATA_SIZE  write data.
- HRDATA  out  HDATA_SIZE  read data.
- HSIZE, HBURST  in  3 each  (HBURST ignored).
- HPROT  in  4  protection.
- HTRANS  in  2  transfer type.
- HREADYOUT, HRESP  out  1 each.
- PCLKEN  in  1  APB clock enable.
- PSEL, PENABLE, PWRITE  out  1 each.
- PPROT  out  3.
- PSTRB  out  PDATA_SIZE/8.
- PADDR  out  PADDR_SIZE.
- PWDATA  out  PDATA_SIZE.
- PRDATA  in  PDATA_SIZE.
- PREADY, PSLVERR  in  1 each.

Behaviour:
- Reset values: HREADYOUT=1; HRESP=OKAY; HRDATA=0; PSEL=PENABLE=PWRITE=0; PPROT=0; PSTRB=0; PADDR=0; PWDATA=0; FSM=IDLE.
- Address-phase accept condition: HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ) in any cycle with HREADYOUT=1, i.e. IDLE or ERR2. IDLE/BUSY gives OKAY with zero wait.
- Latched at accept: HADDR, HWRITE, HSIZE, HPROT.
- FSM states: IDLE, DATA, PEND, SETUP, ACCESS, ERR1, ERR2.
- IDLE -> DATA on accept; HREADYOUT=0.
- DATA, one cycle: HWDATA captured unconditionally.
  - If 8<<HSIZE > HDATA_SIZE -> ERR1, no APB access.
  - Else if PCLKEN -> SETUP.
  - Else -> PEND.
- PEND -> SETUP on PCLKEN.
- SETUP: PSEL=1, PENABLE=0. On PCLKEN -> ACCESS with PENABLE=1.
- ACCESS, PCLKEN & PREADY: PRDATA is merged into HRDATA at the beat's lane.
  - PSLVERR -> ERR1; remaining beats abandoned.
  - Last beat -> IDLE with HREADYOUT=1, HRESP=OKAY, PSEL=PENABLE=0.
  - Otherwise -> SETUP with the next beat's PADDR/PWDATA/PSTRB, PENABLE=0.
- ERR1: HREADYOUT=0, HRESP=ERROR.
- ERR2: HREADYOUT=1, HRESP=ERROR; next cycle -> IDLE or DATA.
- APB-visible register updates occur only on PCLKEN edges. APB signals are stable while PENABLE=1 and PREADY=0.
- Beat count: max(1, (8<<HSIZE)/PDATA_SIZE).
- First PADDR: HADDR[PADDR_SIZE-1:0] rounded down to a PDATA_SIZE/8 byte boundary. Each further beat adds PDATA_SIZE/8, modulo 2^PADDR_SIZE (wraps).
- Lane offset: HADDR mod (HDATA_SIZE/8), rounded down to a PDATA_SIZE/8 byte boundary. PWDATA and the HRDATA merge use HDATA byte lane (lane offset + beat×PDATA_SIZE/8).
- PSTRB on writes: byte lanes of the current PDATA word covered by [HADDR, HADDR+2^HSIZE). PSTRB=0 on reads.
- PPROT mapping: [0]=HPROT[1]; [1]=0; [2]=~HPROT[0].
- HRDATA is cleared at accept; non-accessed lanes read 0.
- Latency with PCLKEN=1 and PREADY=1: a single-beat access has 3 wait states; each extra beat adds 2 cycles.

Optional Feature:
- Macro: PERIPHERAL_AHB3_APB4_TIMEOUT_EN.
- Defined: an 8..16-bit counter counts PCLKEN cycles in ACCESS with PREADY=0. It clears on entering ACCESS.
- On reaching TIMEOUT: PSEL=PENABLE=0, go to ERR1, HRDATA lanes of the aborted beat = 0.
- Undefined: no counter; the bridge waits indefinitely for PREADY.

Decomposition:
- Shared package peripheral_ahb3_pkg: HTRANS_*, HSIZE_*, HRESP_*, HPROT_* constants, and the bridge state enum typedef.
- One sub-module, peripheral_apb4_lane_ctrl (combinational, pure). Inputs: HADDR, HSIZE, beat index. Outputs: PADDR offset, lane offset, PSTRB.

Test Plan:
All scenarios use HDATA=32, PDATA=8, PCLKEN=1 unless stated.
- Word write at 0x100, HWDATA=0xA1B2C3D4 -> 4 APB beats: PADDR 0x100..0x103, PWDATA D4,C3,B2,A1, PSTRB=1 each; HREADYOUT high on cycle 10 after accept, OKAY.
- Halfword read at 0x002, PRDATA 0x11, 0x22 -> PADDR 0x002, 0x003; HRDATA=0x22110000; PSTRB=0.
- PSLVERR on beat 2 of a word write -> no beat 3; ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); then IDLE.
- PCLKEN high every 3rd cycle; PDATA=32 byte write at 0x3 -> PSTRB=4'b1000; PSEL/PENABLE change only on PCLKEN edges.
- DWORD HSIZE on the 32-bit bus -> ERROR response, PSEL never asserted; HRESETn low during ACCESS -> all outputs at reset values immediately.
- With TIMEOUT_EN and TIMEOUT=4, PREADY held 0 -> ERR1 after 4 ACCESS cycles; without the macro, still in ACCESS after 1000 cycles.
